// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types and address decode for the AXI-Lite register file
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_t;

  // Byte address to word index; bits below the bus width are dropped.
  function automatic logic [31:0] addr2idx(input logic [63:0] addr, input int dw);
    return 32'(addr >> ((dw == 64) ? 3 : 2));
  endfunction

endpackage

// File: rtl/axil_skid1.sv
// rtl/axil_skid1.sv - one-entry holding buffer with registered ready, used for AW and W
module axil_skid1 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         pop_i
);

  logic         full_q, full_d;
  logic         ready_q;
  logic [W-1:0] data_q;

  always_comb begin
    full_d = full_q;
    if (pop_i) full_d = 1'b0;
    if (valid_i && ready_q) full_d = 1'b1;
  end

  // ready is held low for the first cycle out of reset, then tracks emptiness
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
      if (valid_i && ready_q) data_q <= data_i;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axil_regfile.sv
// rtl/axil_regfile.sv - AXI4-Lite slave register file; W1C registers enabled by AXIL_REGFILE_W1C_EN
module axil_regfile
  import axil_pkg::*;
#(
  parameter int                  C_AXI_DATA_WIDTH = 32,
  parameter int                  C_AXI_ADDR_WIDTH = 9,
  parameter int                  NUM_REGS         = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK          = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK         = '0
) (
  input  logic                               AXI_ACLK,
  input  logic                               AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]        AXI_AWADDR,
  input  logic [2:0]                         AXI_AWPROT,
  input  logic                               AXI_AWVALID,
  output logic                               AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]        AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]      AXI_WSTRB,
  input  logic                               AXI_WVALID,
  output logic                               AXI_WREADY,
  output logic [1:0]                         AXI_BRESP,
  output logic                               AXI_BVALID,
  input  logic                               AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]        AXI_ARADDR,
  input  logic [2:0]                         AXI_ARPROT,
  input  logic                               AXI_ARVALID,
  output logic                               AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]        AXI_RDATA,
  output logic [1:0]                         AXI_RRESP,
  output logic                               AXI_RVALID,
  input  logic                               AXI_RREADY,
  output logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                wr_pulse,
  input  logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] set_in
);

  localparam int          DW = C_AXI_DATA_WIDTH;
  localparam int          SW = DW / 8;
  localparam int          AW = C_AXI_ADDR_WIDTH;
  localparam logic [31:0] NR = 32'(NUM_REGS);

  logic          aw_full, w_full, commit;
  logic [AW-1:0] aw_addr;
  logic [SW+DW-1:0] w_buf;
  logic [DW-1:0] wdata, bmask;
  logic [SW-1:0] wstrb;
  logic [31:0]   widx, ridx;
  logic          w_in_range;

  logic          bvalid_q;
  resp_t         bresp_q;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];

  rd_state_t     rd_state_q;
  logic          arready_q, rvalid_q;
  logic [DW-1:0] rdata_q, rd_value;
  resp_t         rresp_q;

  axil_skid1 #(.W(AW)) u_aw_buf (
    .clk_i(AXI_ACLK), .rst_ni(AXI_ARESETN), .valid_i(AXI_AWVALID), .ready_o(AXI_AWREADY),
    .data_i(AXI_AWADDR), .valid_o(aw_full), .data_o(aw_addr), .pop_i(commit)
  );

  axil_skid1 #(.W(SW+DW)) u_w_buf (
    .clk_i(AXI_ACLK), .rst_ni(AXI_ARESETN), .valid_i(AXI_WVALID), .ready_o(AXI_WREADY),
    .data_i({AXI_WSTRB, AXI_WDATA}), .valid_o(w_full), .data_o(w_buf), .pop_i(commit)
  );

  assign wdata      = w_buf[DW-1:0];
  assign wstrb      = w_buf[DW+:SW];
  assign commit     = aw_full && w_full && !bvalid_q;
  assign widx       = addr2idx({{(64-AW){1'b0}}, aw_addr}, DW);
  assign ridx       = addr2idx({{(64-AW){1'b0}}, AXI_ARADDR}, DW);
  assign w_in_range = widx < NR;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < SW; b++) bmask[b*8 +: 8] = {8{wstrb[b]}};
  end

  // wr_pulse fires for RO registers too, so core logic sees every in-range write
  always_comb begin
    wr_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (commit && w_in_range && widx == 32'(i)) wr_pulse[i] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_pulse[i] && !RO_MASK[i]) begin
`ifdef AXIL_REGFILE_W1C_EN
        if (W1C_MASK[i]) regs_d[i] = regs_q[i] & ~(wdata & bmask);
        else             regs_d[i] = (regs_q[i] & ~bmask) | (wdata & bmask);
`else
        regs_d[i] = (regs_q[i] & ~bmask) | (wdata & bmask);
`endif
      end
`ifdef AXIL_REGFILE_W1C_EN
      if (W1C_MASK[i]) regs_d[i] = regs_d[i] | set_in[i*DW +: DW];
`endif
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      if (bvalid_q && AXI_BREADY) bvalid_q <= 1'b0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_in_range ? OKAY : SLVERR;
      end
    end
  end

  always_comb begin
    reg_out  = '0;
    rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DW +: DW] = regs_q[i];
      if (ridx == 32'(i)) rd_value = RO_MASK[i] ? reg_in[i*DW +: DW] : regs_q[i];
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      rd_state_q <= IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      case (rd_state_q)
        IDLE: begin
          if (AXI_ARVALID && arready_q) begin
            rd_state_q <= RESP;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_value;
            rresp_q    <= (ridx < NR) ? OKAY : SLVERR;
          end else begin
            arready_q  <= 1'b1;
          end
        end
        RESP: begin
          if (AXI_RREADY) begin
            rd_state_q <= IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
        default: rd_state_q <= IDLE;
      endcase
    end
  end

  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_ARREADY = arready_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;

  logic unused_ok;
`ifdef AXIL_REGFILE_W1C_EN
  assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT};
`else
  assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT, set_in, W1C_MASK};
`endif

endmodule

// File: tb/tb_axil_regfile.sv
// tb/tb_axil_regfile.sv - bench for axil_regfile; W1C checks built with AXIL_REGFILE_W1C_EN
module tb_axil_regfile;

  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0008;

  logic AXI_ACLK = 1'b0;
  logic AXI_ARESETN;
  logic [8:0] AXI_AWADDR, AXI_ARADDR;
  logic [2:0] AXI_AWPROT, AXI_ARPROT;
  logic AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY, AXI_BVALID, AXI_BREADY;
  logic AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
  logic [31:0] AXI_WDATA, AXI_RDATA;
  logic [3:0] AXI_WSTRB;
  logic [1:0] AXI_BRESP, AXI_RRESP;
  logic [NR*32-1:0] reg_out, reg_in, set_in;
  logic [NR-1:0] wr_pulse;

  int tests = 0;
  int fails = 0;

  axil_regfile #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(9), .NUM_REGS(NR),
    .RO_MASK(RO), .W1C_MASK(16'h0010)
  ) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESETN(AXI_ARESETN),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .set_in(set_in)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    tests++;
    fails++;
    $display("FAIL %s actual=no handshake required=handshake within 50 cycles", nm);
  endtask

  // Transaction-level model: pending AW/W beats, outstanding B/R, register contents.
  logic [31:0] m_regs [NR];
  logic        m_ok, m_aw_full, m_w_full, m_bvalid, m_rvalid;
  logic [8:0]  m_aw_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  function automatic bit m_commit();
    return m_aw_full && m_w_full && !m_bvalid;
  endfunction

  function automatic bit in_range(input logic [8:0] a);
    return int'(a >> 2) < NR;
  endfunction

  function automatic logic [31:0] next_reg(input int i);
    logic [31:0] v;
    v = m_regs[i];
    if (m_commit() && in_range(m_aw_addr) && int'(m_aw_addr >> 2) == i && !RO[i]) begin
      for (int b = 0; b < 4; b++) begin
        if (m_wstrb[b]) begin
`ifdef AXIL_REGFILE_W1C_EN
          if (i == 4) v[b*8 +: 8] = v[b*8 +: 8] & ~m_wdata[b*8 +: 8];
          else        v[b*8 +: 8] = m_wdata[b*8 +: 8];
`else
          v[b*8 +: 8] = m_wdata[b*8 +: 8];
`endif
        end
      end
    end
`ifdef AXIL_REGFILE_W1C_EN
    if (i == 4) v = v | set_in[i*32 +: 32];
`endif
    return v;
  endfunction

  function automatic logic [31:0] read_val(input logic [8:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx >= NR) return 32'h0;
    if (RO[idx]) return reg_in[idx*32 +: 32];
    return m_regs[idx];
  endfunction

  always @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      for (int i = 0; i < NR; i++) m_regs[i] <= '0;
      m_ok <= 1'b0; m_aw_full <= 1'b0; m_w_full <= 1'b0;
      m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      m_aw_addr <= '0; m_wdata <= '0; m_wstrb <= '0;
      m_bresp <= 2'b00; m_rresp <= 2'b00; m_rdata <= '0;
    end else begin
      for (int i = 0; i < NR; i++) m_regs[i] <= next_reg(i);
      if (m_bvalid && AXI_BREADY) m_bvalid <= 1'b0;
      if (m_commit()) begin
        m_bvalid  <= 1'b1;
        m_bresp   <= in_range(m_aw_addr) ? 2'b00 : 2'b10;
        m_aw_full <= 1'b0;
        m_w_full  <= 1'b0;
      end
      if (AXI_AWVALID && m_ok && !m_aw_full) begin
        m_aw_full <= 1'b1;
        m_aw_addr <= AXI_AWADDR;
      end
      if (AXI_WVALID && m_ok && !m_w_full) begin
        m_w_full <= 1'b1;
        m_wdata  <= AXI_WDATA;
        m_wstrb  <= AXI_WSTRB;
      end
      if (!m_rvalid && m_ok && AXI_ARVALID) begin
        m_rvalid <= 1'b1;
        m_rdata  <= read_val(AXI_ARADDR);
        m_rresp  <= in_range(AXI_ARADDR) ? 2'b00 : 2'b10;
      end else if (m_rvalid && AXI_RREADY) begin
        m_rvalid <= 1'b0;
      end
      m_ok <= 1'b1;
    end
  end

  always @(negedge AXI_ACLK) begin
    logic [NR-1:0]    e_pulse;
    logic [NR*32-1:0] e_regs;
    e_pulse = '0;
    if (m_commit() && in_range(m_aw_addr)) e_pulse[m_aw_addr >> 2] = 1'b1;
    for (int i = 0; i < NR; i++) e_regs[i*32 +: 32] = m_regs[i];
    chk("cyc_awready", AXI_AWREADY, m_ok && !m_aw_full);
    chk("cyc_wready", AXI_WREADY, m_ok && !m_w_full);
    chk("cyc_arready", AXI_ARREADY, m_ok && !m_rvalid);
    chk("cyc_bvalid", AXI_BVALID, m_bvalid);
    chk("cyc_rvalid", AXI_RVALID, m_rvalid);
    chk("cyc_wr_pulse", wr_pulse, e_pulse);
    chk("cyc_reg_out", reg_out, e_regs);
    if (m_bvalid) chk("cyc_bresp", AXI_BRESP, m_bresp);
    if (m_rvalid) chk("cyc_rdata_rresp", {AXI_RRESP, AXI_RDATA}, {m_rresp, m_rdata});
  end

  task automatic send_aw(input logic [8:0] a);
    int n;
    @(posedge AXI_ACLK); #1;
    AXI_AWADDR = a; AXI_AWVALID = 1'b1;
    n = 0;
    @(negedge AXI_ACLK);
    while (!AXI_AWREADY && n < 50) begin @(negedge AXI_ACLK); n++; end
    if (!AXI_AWREADY) tmo("aw_handshake");
    @(posedge AXI_ACLK); #1;
    AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    @(posedge AXI_ACLK); #1;
    AXI_WDATA = d; AXI_WSTRB = s; AXI_WVALID = 1'b1;
    n = 0;
    @(negedge AXI_ACLK);
    while (!AXI_WREADY && n < 50) begin @(negedge AXI_ACLK); n++; end
    if (!AXI_WREADY) tmo("w_handshake");
    @(posedge AXI_ACLK); #1;
    AXI_WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [8:0] a);
    int n;
    @(posedge AXI_ACLK); #1;
    AXI_ARADDR = a; AXI_ARVALID = 1'b1;
    n = 0;
    @(negedge AXI_ACLK);
    while (!AXI_ARREADY && n < 50) begin @(negedge AXI_ACLK); n++; end
    if (!AXI_ARREADY) tmo("ar_handshake");
    @(posedge AXI_ACLK); #1;
    AXI_ARVALID = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n;
    n = 0;
    @(negedge AXI_ACLK);
    while (!AXI_BVALID && n < 50) begin @(negedge AXI_ACLK); n++; end
    if (!AXI_BVALID) tmo("b_handshake");
    r = AXI_BRESP;
    @(posedge AXI_ACLK); #1;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    @(negedge AXI_ACLK);
    while (!AXI_RVALID && n < 50) begin @(negedge AXI_ACLK); n++; end
    if (!AXI_RVALID) tmo("r_handshake");
    d = AXI_RDATA; r = AXI_RRESP;
    @(posedge AXI_ACLK); #1;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b(r);
  endtask

  task automatic do_read(input logic [8:0] a, output logic [31:0] d, output logic [1:0] r);
    send_ar(a);
    wait_r(d, r);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    AXI_ARESETN = 1'b0;
    AXI_AWADDR = '0; AXI_AWPROT = 3'b010; AXI_AWVALID = 1'b0;
    AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WVALID = 1'b0; AXI_BREADY = 1'b1;
    AXI_ARADDR = '0; AXI_ARPROT = 3'b001; AXI_ARVALID = 1'b0; AXI_RREADY = 1'b1;
    reg_in = '0; reg_in[3*32 +: 32] = 32'hCAFE0000;
    set_in = '0;
    repeat (3) @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    chk("rst_readies", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b000);
    chk("rst_valids", {AXI_BVALID, AXI_RVALID}, 2'b00);
    chk("rst_resp_data", {AXI_BRESP, AXI_RRESP, AXI_RDATA}, 36'h0);
    chk("rst_reg_out", reg_out, '0);
    @(posedge AXI_ACLK); #1;
    AXI_ARESETN = 1'b1;
    repeat (2) @(posedge AXI_ACLK);

    do_write(9'h004, 32'hDEADBEEF, 4'hF, r);
    chk("t1_bresp", r, 2'b00);
    chk("t1_reg1", reg_out[63:32], 32'hDEADBEEF);
    do_read(9'h004, d, r);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", r, 2'b00);

    send_w(32'h11223344, 4'b0101);
    repeat (3) begin
      @(negedge AXI_ACLK);
      chk("t2_no_b_before_aw", AXI_BVALID, 1'b0);
    end
    send_aw(9'h008);
    wait_b(r);
    chk("t2_bresp", r, 2'b00);
    chk("t2_reg2", reg_out[95:64], 32'h00220044);

    do_write(9'h040, 32'h12345678, 4'hF, r);
    chk("t3_bresp", r, 2'b10);
    chk("t3_regs_kept", reg_out[95:0], {32'h00220044, 32'hDEADBEEF, 32'h0});
    do_read(9'h040, d, r);
    chk("t3_rdata", d, 32'h0);
    chk("t3_rresp", r, 2'b10);

    AXI_BREADY = 1'b0;
    fork send_aw(9'h014); send_w(32'hA5A5A5A5, 4'hF); join
    fork send_aw(9'h018); send_w(32'h5A5A5A5A, 4'hF); join
    repeat (3) begin
      @(negedge AXI_ACLK);
      chk("t4_stall_ready", {AXI_AWREADY, AXI_WREADY, AXI_BVALID}, 3'b001);
    end
    chk("t4_second_held", reg_out[223:192], 32'h0);
    @(posedge AXI_ACLK); #1;
    AXI_BREADY = 1'b1;
    wait_b(r);
    chk("t4_b1", r, 2'b00);
    wait_b(r);
    chk("t4_b2", r, 2'b00);
    chk("t4_regs", reg_out[223:160], {32'h5A5A5A5A, 32'hA5A5A5A5});

    do_write(9'h00C, 32'hFFFFFFFF, 4'hF, r);
    chk("t5_bresp", r, 2'b00);
    chk("t5_reg3_out", reg_out[127:96], 32'h0);
    do_read(9'h00C, d, r);
    chk("t5_rdata", d, 32'hCAFE0000);
    chk("t5_rresp", r, 2'b00);

`ifdef AXIL_REGFILE_W1C_EN
    @(posedge AXI_ACLK); #1;
    set_in[4*32 +: 32] = 32'h5;
    @(posedge AXI_ACLK); #1;
    set_in = '0;
    chk("w1c_set", reg_out[159:128], 32'h5);
    do_write(9'h010, 32'h1, 4'hF, r);
    chk("w1c_clear", reg_out[159:128], 32'h4);
    set_in[4*32 +: 32] = 32'h1;
    do_write(9'h010, 32'h1, 4'hF, r);
    @(posedge AXI_ACLK); #1;
    set_in = '0;
    chk("w1c_set_wins", reg_out[159:128], 32'h5);
`endif

    AXI_RREADY = 1'b0;
    send_ar(9'h004);
    @(negedge AXI_ACLK);
    chk("rst_mid_rvalid_before", AXI_RVALID, 1'b1);
    #1 AXI_ARESETN = 1'b0;
    #1;
    chk("rst_mid_rvalid", AXI_RVALID, 1'b0);
    chk("rst_mid_regs", reg_out, '0);
    chk("rst_mid_ready", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b000);
    repeat (2) @(posedge AXI_ACLK);
    #1 AXI_ARESETN = 1'b1;
    AXI_RREADY = 1'b1;
    repeat (4) begin
      @(negedge AXI_ACLK);
      chk("rst_no_late_resp", {AXI_BVALID, AXI_RVALID}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
Parametrised AXI4-Lite slave register file, the next-generation endpoint for the team's AXI-Lite bus. Provides NUM_REGS registers of C_AXI_DATA_WIDTH bits each, with per-register read-only mode, byte strobes, SLVERR decode and independent AW/W acceptance. Sits behind the system AXI-Lite interconnect and exports register contents and write pulses to core logic.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width; 32 or 64.
C_AXI_ADDR_WIDTH, 9, byte address width.
NUM_REGS, 16, implemented registers, 1..2^(C_AXI_ADDR_WIDTH-log2(C_AXI_DATA_WIDTH/8)).
RO_MASK, '0, bit i=1 makes reg i read-only; it reads from reg_in.
W1C_MASK, '0, bit i=1 makes reg i write-1-to-clear. Used only with the optional feature.

Ports:
AXI_ACLK  in  1  clock
AXI_ARESETN  in  1  async active-low reset
AXI_AWADDR/AWPROT/AWVALID in, AXI_AWREADY out  C_AXI_ADDR_WIDTH/3/1/1  write address channel
AXI_WDATA/WSTRB/WVALID in, AXI_WREADY out  DW/DW/8/1/1  write data channel
AXI_BRESP/BVALID out, AXI_BREADY in  2/1/1  write response channel
AXI_ARADDR/ARPROT/ARVALID in, AXI_ARREADY out  C_AXI_ADDR_WIDTH/3/1/1  read address channel
AXI_RDATA/RRESP/RVALID out, AXI_RREADY in  DW/2/1/1  read data channel
reg_out  out  NUM_REGS*DW  flattened register contents; reg i sits at [i*DW +: DW]
reg_in  in  NUM_REGS*DW  values returned for RO registers
wr_pulse  out  NUM_REGS  one-cycle strobe on the cycle reg i is written
set_in  in  NUM_REGS*DW  hardware set bits for W1C registers

Behaviour:
- Clock is AXI_ACLK. Reset is AXI_ARESETN: asynchronous assert, active-low, synchronous deassert handled externally. On reset: all READY, VALID, BRESP, RRESP, RDATA, wr_pulse and every register are 0.
- Word index = addr[C_AXI_ADDR_WIDTH-1:log2(DW/8)]. Low address bits are ignored. An index >= NUM_REGS is out of range. AxPROT is ignored.
- Write path:
  - AW and W are accepted independently, each into a one-entry holding buffer. AWREADY=1 when its buffer is empty; the same holds for WREADY.
  - When both buffers are full and BVALID=0, the write commits in that cycle, BVALID rises on the next edge, and both buffers free.
  - Commit updates each byte whose WSTRB bit is set and pulses wr_pulse[i] for one cycle in the commit cycle; the register value is visible on reg_out the cycle after.
  - BRESP is 2'b00 (OKAY) in range and 2'b10 (SLVERR) out of range. An out-of-range write has no side effects.
  - A write to an RO register returns OKAY and changes nothing; wr_pulse is still asserted.
  - BVALID holds until BREADY. While BVALID=1 no commit occurs, so a third beat on either channel stalls.
- Read path:
  - Two states: IDLE (ARREADY=1) and RESP (RVALID=1, ARREADY=0).
  - The AR handshake latches RDATA/RRESP on the next edge and enters RESP. RESP returns to IDLE on RVALID&&RREADY.
  - Out-of-range reads give RDATA=0 and RRESP=SLVERR. RO registers return the sampled reg_in.
- Read and write in the same cycle to the same register: the read returns the pre-write value.
- Peak throughput is one write per 2 cycles (commit, then B) and one read per 2 cycles. There is no combinational path from input to output.
- Reset mid-transaction abandons any outstanding B/R response. No response is issued after reset.

Optional Feature:
AXIL_REGFILE_W1C_EN.
- Defined: for each W1C_MASK register, every cycle reg |= set_in slice, and an AXI write clears the bits where WDATA=1 and the byte strobe is set.
  - Set has priority over clear in the same cycle.
  - wr_pulse is asserted on the write as normal.
- Undefined: W1C_MASK and set_in are ignored. Those registers behave as RW; set_in stays in the port list, unused.

Decomposition:
- Package axil_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - rd_state_t enum: IDLE, RESP.
  - Function addr2idx(addr, dw).
- One sub-module, axil_skid1: a one-entry holding buffer with valid/ready, instantiated for both AW and W.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x04 with WSTRB=4'hF → BRESP=OKAY. reg_out[63:32]=0xDEADBEEF, wr_pulse[1] high for 1 cycle. Readback gives RDATA=0xDEADBEEF, RRESP=OKAY.
- Write W three cycles before AW, with 0x11223344 to addr 0x08 and WSTRB=4'b0101 over reg=0 → reg2=0x00220044. BVALID appears only after AW.
- Write and read addr 0x40 with NUM_REGS=16 → BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no reg_out change.
- Hold BREADY=0 and present two further AW/W → second beat accepted into the buffers, third stalls (AWREADY=0). Release BREADY → second write commits.
- RO_MASK bit 3 set, reg_in slice 3=0xCAFE0000, write 0xFFFFFFFF to 0x0C → OKAY. Read returns 0xCAFE0000.
- With W1C_EN, W1C_MASK bit 4: set_in=0x5 for one cycle, then write 0x1 to 0x10 → reg4=0x4. Set and clear of bit 0 in the same cycle → bit stays 1.
- Assert AXI_ARESETN=0 while RVALID=1 → RVALID=0 immediately, all registers 0.
